// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
// Multi-cycle magnitude comparator. Walks two WIDTH-bit operands one SLICE-bit
// digit per clock, most significant digit first, and stops at the first digit
// that differs. Supports unsigned and two's-complement signed ordering.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        launch request (accepted in idle and in the done cycle)
//   signed_mode  1 = two's-complement compare, 0 = unsigned (captured with start)
//   a, b         operands (captured with start)
//   busy         compare in progress
//   done         one-cycle pulse, result flags just updated
//   gt, eg, ut   A > B, A == B, A < B (hold until the next result)
// -----------------------------------------------------------------------------
module serial_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eg,
  output logic             ut
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int ND = 2 ** KW;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eg_q, eg_d;
  logic             ut_q, ut_d;

  // Digit tables padded to a power of two so k_q indexes them at its natural
  // width; padding entries are never selected.
  logic [SLICE-1:0] a_dig [ND];
  logic [SLICE-1:0] b_dig [ND];
  logic [SLICE-1:0] dig_a;
  logic [SLICE-1:0] dig_b;
  logic             flip_top;

  for (genvar i = 0; i < ND; i++) begin : g_dig
    if (i < N) begin : g_real
      assign a_dig[i] = a_q[WIDTH-1-i*SLICE -: SLICE];
      assign b_dig[i] = b_q[WIDTH-1-i*SLICE -: SLICE];
    end else begin : g_pad
      assign a_dig[i] = {SLICE{1'b0}};
      assign b_dig[i] = {SLICE{1'b0}};
    end
  end

  // Current digit pair; on the most significant digit in signed mode the sign
  // bits are inverted so two's-complement order becomes unsigned order.
  always_comb begin
    flip_top         = sm_q && (k_q == {KW{1'b0}});
    dig_a            = a_dig[k_q];
    dig_b            = b_dig[k_q];
    dig_a[SLICE-1]   = a_dig[k_q][SLICE-1] ^ flip_top;
    dig_b[SLICE-1]   = b_dig[k_q][SLICE-1] ^ flip_top;
  end

  // Next-state, capture and result logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eg_d    = eg_q;
    ut_d    = ut_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          k_d     = {KW{1'b0}};
          busy_d  = 1'b1;
          state_d = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (dig_a != dig_b) begin
          gt_d    = (dig_a > dig_b);
          ut_d    = (dig_a < dig_b);
          eg_d    = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (k_q == K_LAST) begin
          gt_d    = 1'b0;
          ut_d    = 1'b0;
          eg_d    = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= {KW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eg_q    <= 1'b0;
      ut_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eg_q    <= eg_d;
      ut_q    <= ut_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eg   = eg_q;
  assign ut   = ut_q;

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
// Self-checking bench for serial_comparator. Three instances share clock,
// reset and operand buses: 16/4 (main), 8/8 (single digit) and 32/1 (bitwise).
// Expected flags come from signed/unsigned integer comparison; expected
// latency from the index of the first differing digit.
// -----------------------------------------------------------------------------
module tb_serial_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  logic        sm = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic        busy0, done0, gt0, eg0, ut0;
  logic        busy1, done1, gt1, eg1, ut1;
  logic        busy2, done2, gt2, eg2, ut2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(16), .SLICE(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm),
    .a(a_in[15:0]), .b(b_in[15:0]),
    .busy(busy0), .done(done0), .gt(gt0), .eg(eg0), .ut(ut0));

  serial_comparator #(.WIDTH(8), .SLICE(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm),
    .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy1), .done(done1), .gt(gt1), .eg(eg1), .ut(ut1));

  serial_comparator #(.WIDTH(32), .SLICE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm),
    .a(a_in), .b(b_in),
    .busy(busy2), .done(done2), .gt(gt2), .eg(eg2), .ut(ut2));

  // {busy, done, gt, eg, ut} of the selected instance
  function automatic logic [4:0] obs(input int which);
    case (which)
      0:       return {busy0, done0, gt0, eg0, ut0};
      1:       return {busy1, done1, gt1, eg1, ut1};
      default: return {busy2, done2, gt2, eg2, ut2};
    endcase
  endfunction

  function automatic int width_of(input int which);
    case (which)
      0:       return 16;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int slice_of(input int which);
    case (which)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: integer compare for flags, first differing digit for latency.
  task automatic ref_cmp(input int w, input int s, input logic [31:0] aa,
                         input logic [31:0] bb, input logic smode,
                         output logic [2:0] flags, output int lat);
    longint va, vb, m, da, db;
    int n;
    bit found;
    m  = (64'sd1 <<< w) - 64'sd1;
    va = longint'(aa) & m;
    vb = longint'(bb) & m;
    if (smode && va[w-1]) va = va - (64'sd1 <<< w);
    if (smode && vb[w-1]) vb = vb - (64'sd1 <<< w);
    flags = {va > vb, va == vb, va < vb};
    n = w / s;
    lat = n;
    found = 1'b0;
    for (int j = 0; j < n; j++) begin
      da = (longint'(aa) >>> (w - (j + 1) * s)) & ((64'sd1 <<< s) - 64'sd1);
      db = (longint'(bb) >>> (w - (j + 1) * s)) & ((64'sd1 <<< s) - 64'sd1);
      if (!found && da != db) begin
        lat = j + 1;
        found = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Drive operands + start at a negedge, then release start one cycle later.
  task automatic start_cmp(input int which, input logic [31:0] aa,
                           input logic [31:0] bb, input logic smode);
    a_in = aa;
    b_in = bb;
    sm   = smode;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
  endtask

  // Called one half-cycle after the accepting edge; waits for done and checks.
  task automatic finish_cmp(input int which, input logic [31:0] aa,
                            input logic [31:0] bb, input logic smode,
                            input bit abuse, input string tag);
    logic [2:0] ef;
    int el;
    int cnt;
    logic [4:0] o;
    ref_cmp(width_of(which), slice_of(which), aa, bb, smode, ef, el);
    o = obs(which);
    chk({tag, "_busy_start"}, {31'd0, o[4]}, 32'd1);
    chk({tag, "_nodone_start"}, {31'd0, o[3]}, 32'd0);
    cnt = 0;
    while (obs(which) [3] !== 1'b1 && cnt < 64) begin
      @(negedge clk);
      cnt++;
      if (abuse && cnt == 1) begin
        set_start(which, 1'b1);
        a_in = ~aa;
        b_in = $urandom;
        sm   = ~smode;
      end else if (abuse && cnt == 2) begin
        set_start(which, 1'b0);
      end
    end
    set_start(which, 1'b0);
    o = obs(which);
    chk({tag, "_done"}, {31'd0, o[3]}, 32'd1);
    chk({tag, "_latency"}, cnt, el);
    chk({tag, "_flags"}, {29'd0, o[2:0]}, {29'd0, ef});
    chk({tag, "_busy_at_done"}, {31'd0, o[4]}, 32'd0);
  endtask

  task automatic run_cmp(input int which, input logic [31:0] aa,
                         input logic [31:0] bb, input logic smode,
                         input bit abuse, input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse_ended"}, {31'd0, obs(which) [3]}, 32'd0);
    start_cmp(which, aa, bb, smode);
    finish_cmp(which, aa, bb, smode, abuse, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    int mode;

    // Reset state
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) chk("reset_outputs", {27'd0, obs(w)}, 32'd0);
    rst = 1'b0;

    // Directed cases on 16/4
    run_cmp(0, 32'h1234, 32'h1235, 1'b0, 1'b0, "late_diff");
    run_cmp(0, 32'h8000, 32'h7FFF, 1'b0, 1'b0, "early_unsigned");
    chk("early_unsigned_gt", {31'd0, gt0}, 32'd1);
    run_cmp(0, 32'h8000, 32'h7FFF, 1'b1, 1'b0, "early_signed");
    chk("early_signed_ut", {31'd0, ut0}, 32'd1);
    run_cmp(0, 32'hABCD, 32'hABCD, 1'b0, 1'b0, "equal");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_idle", {27'd0, obs(0)}, {27'd0, 5'b00010});
    end

    // start and operand changes during CMP are ignored
    run_cmp(0, 32'h1234, 32'h1235, 1'b0, 1'b1, "abuse");

    // Back-to-back: start during the done cycle
    run_cmp(0, 32'h00F0, 32'h0F00, 1'b1, 1'b0, "b2b_first");
    start_cmp(0, 32'hF000, 32'h7001, 1'b1);
    finish_cmp(0, 32'hF000, 32'h7001, 1'b1, 1'b0, "b2b_second");

    // Asynchronous reset mid-compare
    @(negedge clk);
    start_cmp(0, 32'h5555, 32'h5555, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {27'd0, obs(0)}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {31'd0, done0}, 32'd0);
    end
    run_cmp(0, 32'hFFFE, 32'h0001, 1'b1, 1'b0, "after_reset");

    // Randomized sweep on all three geometries
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 20; i++) begin
        ra = $urandom;
        mode = $urandom_range(0, 2);
        case (mode)
          0:       rb = ra;
          1:       rb = ra ^ (32'd1 << $urandom_range(0, width_of(w) - 1));
          default: rb = $urandom;
        endcase
        run_cmp(w, ra, rb, 1'($urandom_range(0, 1)), 1'b0, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
